// File: rtl/mipi_pkg.sv
// Shared types and constants for the MIPI D-PHY HS entry/exit sequencer.
// State codes are visible on state_dbg, so their values are fixed.
package mipi_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_HS_RQST   = 3'd1,
    ST_HS_PREP   = 3'd2,
    ST_HS_RX     = 3'd3,
    ST_WAIT_STOP = 3'd4
  } state_e;

  // LP line pair codes, {lp_p, lp_n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/lp_sync.sv
// Multi-flop synchronizer for the asynchronous LP receiver pair.
// Flops reset to LP-11 so a reset never looks like a request.
module lp_sync #(
  parameter int STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_lp,
  output logic [1:0] o_lp
);

  logic [STAGES-1:0][1:0] r_chain;

  // synchronizer shift chain, both lines move together
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chain <= '1;
    end else begin
      r_chain[0] <= i_lp;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_lp = r_chain[STAGES-1];

endmodule

// File: rtl/mipi_hs_sequencer.sv
// D-PHY data lane HS receive sequencer: walks LP-11 -> LP-01 -> LP-00 into
// HS reception, controls termination and the HS valid window.
module mipi_hs_sequencer
  import mipi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int T_LPX_CYC     = 5,
  parameter int T_SETTLE_CYC  = 15,
  parameter int T_TIMEOUT_CYC = 65535
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       lp_p,
  input  logic       lp_n,
  input  logic       sync_found,
  output logic       termination,
  output logic       hs_active,
  output logic       seq_err,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  // Counter holds completed cycles in the state; comparing against N-1
  // makes the current cycle count towards the dwell.
  localparam logic [CNT_W-1:0] LPX_LAST     = CNT_W'(T_LPX_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(T_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(T_TIMEOUT_CYC - 1);

  logic [1:0]       w_lp;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync_seen;
  logic             w_sync_seen_nxt;
  logic             w_seq_err_nxt;
  logic             w_timeout_err_nxt;
  logic             r_termination;
  logic             r_hs_active;
  logic             r_seq_err;
  logic             r_timeout_err;

  lp_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lp_sync (
    .i_clk   (sys_clk),
    .i_rst_n (reset),
    .i_lp    ({lp_p, lp_n}),
    .o_lp    (w_lp)
  );

  // next-state, counter and error decisions
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_sync_seen_nxt   = r_sync_seen;
    w_seq_err_nxt     = 1'b0;
    w_timeout_err_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt     = ST_WAIT_STOP;
      w_cnt_nxt       = '0;
      w_sync_seen_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_STOP: begin
          case (w_lp)
            LP01: begin
              w_state_nxt = ST_HS_RQST;
              w_cnt_nxt   = '0;
            end
            LP10: begin
              w_state_nxt = ST_WAIT_STOP;
            end
            LP00: begin
              w_state_nxt   = ST_WAIT_STOP;
              w_seq_err_nxt = 1'b1;
            end
            default: begin
              w_state_nxt = ST_STOP;
            end
          endcase
        end
        ST_HS_RQST: begin
          case (w_lp)
            LP00: begin
              if (r_cnt >= LPX_LAST) begin
                w_state_nxt = ST_HS_PREP;
                w_cnt_nxt   = '0;
              end else begin
                w_state_nxt   = ST_WAIT_STOP;
                w_seq_err_nxt = 1'b1;
              end
            end
            LP10: begin
              w_state_nxt   = ST_WAIT_STOP;
              w_seq_err_nxt = 1'b1;
            end
            LP11: begin
              w_state_nxt = ST_STOP;
            end
            default: begin
              w_cnt_nxt = sat_inc(r_cnt);
            end
          endcase
        end
        ST_HS_PREP: begin
          if (r_cnt >= SETTLE_LAST) begin
            w_state_nxt     = ST_HS_RX;
            w_cnt_nxt       = '0;
            w_sync_seen_nxt = 1'b0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
        ST_HS_RX: begin
          // LP-11 wins over a coincident timeout; a sync in the last cycle cancels it
          if (w_lp == LP11) begin
            w_state_nxt = ST_STOP;
          end else if (r_sync_seen || sync_found) begin
            w_sync_seen_nxt = 1'b1;
          end else if (r_cnt >= TIMEOUT_LAST) begin
            w_state_nxt       = ST_WAIT_STOP;
            w_timeout_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
        ST_WAIT_STOP: begin
          if (w_lp == LP11) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_WAIT_STOP;
          end
        end
        default: begin
          w_state_nxt = ST_WAIT_STOP;
        end
      endcase
    end
  end

  // state, counter and registered outputs; outputs follow the next state
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state       <= ST_WAIT_STOP;
      r_cnt         <= '0;
      r_sync_seen   <= 1'b0;
      r_termination <= 1'b0;
      r_hs_active   <= 1'b0;
      r_seq_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sync_seen   <= w_sync_seen_nxt;
      r_termination <= (w_state_nxt == ST_HS_PREP) || (w_state_nxt == ST_HS_RX);
      r_hs_active   <= (w_state_nxt == ST_HS_RX);
      r_seq_err     <= w_seq_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign termination = r_termination;
  assign hs_active   = r_hs_active;
  assign seq_err     = r_seq_err;
  assign timeout_err = r_timeout_err;
  assign state_dbg   = r_state;

endmodule

// File: doc/mipi_hs_sequencer.md
MIPI_HS_SEQUENCER -- requirements
Module: mipi_hs_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on the LP inputs.
REQ-002 SHALL have parameter T_LPX_CYC, default 5, minimum LP-01 dwell in sys_clk cycles.
REQ-003 SHALL have parameter T_SETTLE_CYC, default 15, termination-to-HS-valid delay in cycles.
REQ-004 SHALL have parameter T_TIMEOUT_CYC, default 65535, maximum HS_RX cycles without sync_found (16-bit).
REQ-005 SHALL have ports, one clock, reset synchronous and active-low:
- sys_clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-low
- enable  in  1  lane enable
- lp_p  in  1  asynchronous LP receiver, D+ line
- lp_n  in  1  asynchronous LP receiver, D- line
- sync_found  in  1  pulse from the receiver datapath on HS sync byte detect
- termination  out  1  drives lane 100-ohm termination enable
- hs_active  out  1  HS data valid window for the datapath
- seq_err  out  1  one-cycle pulse, illegal LP sequence
- timeout_err  out  1  one-cycle pulse, no sync byte in time
- state_dbg  out  3  current state code

Function
REQ-010 SHALL synchronize {lp_p,lp_n} through SYNC_STAGES flops. Every state decision uses the synchronized pair lp (1 = p, 0 = n).
REQ-011 SHALL implement states with codes STOP=0, HS_RQST=1, HS_PREP=2, HS_RX=3, WAIT_STOP=4, presented registered on state_dbg.
REQ-012 STOP SHALL branch on lp:
- 01 -> HS_RQST, counter cleared
- 10 -> WAIT_STOP, no error (escape mode unsupported)
- 00 -> WAIT_STOP with seq_err
- 11 -> stay
REQ-013 HS_RQST SHALL count cycles and branch on lp:
- 00 with count >= T_LPX_CYC -> HS_PREP
- 00 with count < T_LPX_CYC -> WAIT_STOP with seq_err
- 10 -> WAIT_STOP with seq_err
- 11 -> STOP, no error
REQ-014 HS_PREP SHALL ignore lp, count T_SETTLE_CYC cycles, then enter HS_RX.
REQ-015 termination SHALL be 1 exactly while the state is HS_PREP or HS_RX. hs_active SHALL be 1 exactly in HS_RX.
REQ-016 HS_RX SHALL exit on lp==11 -> STOP, with termination and hs_active deasserting on the same cycle as the state change.
REQ-017 HS_RX SHALL latch sync_found. If T_TIMEOUT_CYC cycles elapse without it, the block SHALL pulse timeout_err and enter WAIT_STOP.
REQ-018 Simultaneous events SHALL resolve as follows:
- lp==11 beats timeout: STOP, no error
- sync_found in the timeout cycle cancels the timeout
REQ-019 WAIT_STOP SHALL go to STOP only when enable==1 and lp==11.
REQ-020 enable==0 SHALL force WAIT_STOP on the next cycle from any state, with no error pulse.
REQ-021 Latency from an LP-00 pin edge to termination rising SHALL be SYNC_STAGES+1 cycles. hs_active SHALL rise T_SETTLE_CYC cycles after termination.
REQ-022 Counters SHALL saturate, never wrap.

Reset
REQ-030 While reset==0 at a sys_clk edge, the state SHALL be WAIT_STOP (state_dbg=4).
REQ-031 Reset SHALL set termination=0, hs_active=0, seq_err=0 and timeout_err=0.
REQ-032 Reset SHALL clear the counters and sync latch, and set the synchronizer flops to 1 (LP-11).
REQ-033 Reset asserted mid-HS_RX SHALL drop termination on the next edge.

Structure
REQ-040 Package mipi_pkg SHALL hold the state encoding and the LP code constants LP11, LP10, LP01, LP00.
REQ-041 A sub-module lp_sync SHALL implement the parameterized 2-bit synchronizer.

Verification
REQ-050 Legal SoT: LP 11->01 (8 cycles)->00, sync_found 30 cycles later, then 11. Required response:
- termination rises 3 cycles after 00
- hs_active rises 15 cycles after termination
- both fall on the 11 return, no errors
REQ-051 Short LP-01: 01 for 3 cycles, then 00. Required response: seq_err single pulse, state 4, termination never set.
REQ-052 No sync: T_TIMEOUT_CYC=100 with no sync_found. Required response: timeout_err on HS_RX cycle 100, then state 4; only lp 11 returns the block to STOP.
REQ-053 Abort: 11->01->11. Required response: STOP with no error pulses.
REQ-054 enable dropped mid-HS_RX. Required response: next cycle state 4 with termination=0, no errors. enable restored with LP-11 -> STOP.
REQ-055 reset=0 mid-HS_PREP. Required response: all outputs 0 and state 4 after that edge.
